// File: rtl/pipe_ctrl_pkg.sv
// Shared helpers for the pipeline control register chain: occupancy counter
// width and the all-zero NOP control word.
package pipe_ctrl_pkg;

    localparam int unsigned NOP_MAX_W = 1024;
    localparam logic [NOP_MAX_W-1:0] NOP_CTRL = '0;

    function automatic int occ_w(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_cell.sv
// One pipeline slot: main register plus skid register, valid/ready handshake,
// synchronous rst/flush. Empty slots hold and present the NOP word.
module pipe_ctrl_cell
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             main_vld_q, main_vld_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             accept;
    logic             pop;

    // Ready depends only on the skid flag, so backpressure never ripples
    // combinationally through the chain.
    assign in_ready = !skid_vld_q;
    assign accept   = in_valid && !skid_vld_q && !flush;
    assign pop      = main_vld_q && out_ready;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (rst || flush) begin
            main_vld_d  = 1'b0;
            main_data_d = NOP_CTRL[WIDTH-1:0];
            skid_vld_d  = 1'b0;
            skid_data_d = NOP_CTRL[WIDTH-1:0];
        end else if (!main_vld_q) begin
            if (accept) begin
                main_vld_d  = 1'b1;
                main_data_d = in_data;
            end
        end else if (pop) begin
            if (skid_vld_q) begin
                main_vld_d  = 1'b1;
                main_data_d = skid_data_q;
                skid_vld_d  = accept;
                skid_data_d = accept ? in_data : NOP_CTRL[WIDTH-1:0];
            end else begin
                main_vld_d  = accept;
                main_data_d = accept ? in_data : NOP_CTRL[WIDTH-1:0];
            end
        end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q  <= 1'b0;
            main_data_q <= NOP_CTRL[WIDTH-1:0];
            skid_vld_q  <= 1'b0;
            skid_data_q <= NOP_CTRL[WIDTH-1:0];
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign out_valid = main_vld_q;
    assign out_data  = main_vld_q ? main_data_q : NOP_CTRL[WIDTH-1:0];

endmodule

// File: rtl/pipe_ctrl_stage.sv
// Chain of STAGES skid-buffered control register slots with flush.
// Optional occupancy counter port occ enabled by macro PIPE_CTRL_STAGE_OCC_EN.
module pipe_ctrl_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH  = 7,
    parameter int STAGES = 1,
    localparam int OCC_W = occ_w(STAGES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_CTRL_STAGE_OCC_EN
    ,
    output logic [OCC_W-1:0] occ
`endif
);

    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;
    logic [WIDTH-1:0] dat [STAGES+1];

    assign vld[0]      = in_valid;
    assign dat[0]      = in_data;
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : gen_cell
        pipe_ctrl_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_valid (vld[k]),
            .in_data  (dat[k]),
            .in_ready (rdy[k]),
            .out_valid(vld[k+1]),
            .out_data (dat[k+1]),
            .out_ready(rdy[k+1])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES];
    assign out_data  = dat[STAGES];

`ifdef PIPE_CTRL_STAGE_OCC_EN
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             occ_inc;
    logic             occ_dec;

    assign occ_inc = in_valid && in_ready && !flush;
    assign occ_dec = out_valid && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (rst || flush) begin
            occ_d = '0;
        end else if (occ_inc && !occ_dec) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (occ_dec && !occ_inc) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;

`ifndef SYNTHESIS
    occ_bound_a : assert property (@(posedge clk) disable iff (rst)
        occ_q <= OCC_W'(2 * STAGES));
`endif
`endif

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Bench for pipe_ctrl_stage (STAGES=2): cycle table plus scoreboard-checked
// sequences for backpressure, flush, reset and occupancy.
module tb_pipe_ctrl_stage;

    localparam int WIDTH  = 7;
    localparam int STAGES = 2;
    localparam int OCC_W  = $clog2(2 * STAGES + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b1;
`ifdef PIPE_CTRL_STAGE_OCC_EN
    logic [OCC_W-1:0] occ;
`endif

    always #5 clk = ~clk;

    pipe_ctrl_stage #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
`ifdef PIPE_CTRL_STAGE_OCC_EN
        ,
        .occ      (occ)
`endif
    );

    int               n_chk = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] sb [$];

    typedef struct {
        logic             rst;
        logic             flush;
        logic             iv;
        logic [WIDTH-1:0] id;
        logic             ordy;
        logic             ev;
        logic [WIDTH-1:0] ed;
        logic             erdy;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshakes are observed at the negedge, where inputs and outputs are stable
    // for the coming rising edge; outputs are then examined 1ns after that edge.
    task automatic tick();
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL out_unexpected: got %0h expected none", out_data);
                end else begin
                    exp = sb.pop_front();
                    chk("out_order", 32'(out_data), 32'(exp));
                end
            end
            if (!out_valid) chk("bubble_zero", 32'(out_data), 32'(0));
            if (in_valid && in_ready) sb.push_back(in_data);
        end
        @(posedge clk);
        #1;
`ifdef PIPE_CTRL_STAGE_OCC_EN
        chk("occ_model", 32'(occ), 32'(sb.size()));
`endif
    endtask

    task automatic measure_latency(input logic [WIDTH-1:0] w);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = w;
        chk("lat_in_ready", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(STAGES));
        chk("latency_data", 32'(out_data), 32'(w));
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while ((sb.size() > 0 || out_valid) && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        //            rst flush iv id     ordy ev ed     erdy
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 7'h01, 1'b1, 1'b0, 7'h00, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 7'h02, 1'b1, 1'b1, 7'h01, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 7'h03, 1'b1, 1'b1, 7'h02, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 7'h03, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 7'h55, 1'b0, 1'b0, 7'h00, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 7'h55, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 7'h55, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 7'h2A, 1'b1, 1'b0, 7'h00, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 7'h33, 1'b1, 1'b0, 7'h00, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1};

        for (int i = 0; i < 14; i++) begin
            rst       = tbl[i].rst;
            flush     = tbl[i].flush;
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            tick();
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
        end
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;

        // Backpressure: fill all 2*STAGES slots, hold a fifth word upstream.
        out_ready = 1'b0;
        for (int i = 0; i < 2 * STAGES; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(8'h11 + i);
            chk("bp_ready_before_full", 32'(in_ready), 32'(1));
            tick();
        end
        in_data = 7'h15;
        chk("bp_full_ready", 32'(in_ready), 32'(0));
        chk("bp_head_valid", 32'(out_valid), 32'(1));
        chk("bp_head_data", 32'(out_data), 32'(7'h11));
        tick();
        tick();
        chk("bp_still_full", 32'(in_ready), 32'(0));
        chk("bp_head_held", 32'(out_data), 32'(7'h11));
        out_ready = 1'b1;
        tick();
        chk("bp_nogap0", 32'(out_valid), 32'(1));
        tick();
        chk("bp_ready_back", 32'(in_ready), 32'(1));
        chk("bp_nogap1", 32'(out_valid), 32'(1));
        tick();
        in_valid = 1'b0;
        chk("bp_nogap2", 32'(out_valid), 32'(1));
        tick();
        chk("bp_nogap3", 32'(out_valid), 32'(1));
        chk("bp_last_data", 32'(out_data), 32'(7'h15));
        drain();

        // Flush while full, with a word offered on the flush edge.
        out_ready = 1'b0;
        for (int i = 0; i < 2 * STAGES; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(8'h21 + i);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 7'h7F;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_out_data", 32'(out_data), 32'(0));
        chk("flush_in_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("flush_stays_empty", 32'(out_valid), 32'(0));
        end
        measure_latency(7'h2A);
        drain();

        // Reset with words in flight.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 7'h31;
        tick();
        in_data = 7'h32;
        tick();
        in_data = 7'h33;
        rst     = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        measure_latency(7'h2A);
        drain();

`ifdef PIPE_CTRL_STAGE_OCC_EN
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(8'h41 + i);
            tick();
        end
        chk("occ_three", 32'(occ), 32'(3));
        out_ready = 1'b1;
        in_data   = 7'h44;
        tick();
        chk("occ_push_pop", 32'(occ), 32'(3));
        in_data = 7'h45;
        tick();
        in_valid = 1'b0;
        drain();
        chk("occ_zero", 32'(occ), 32'(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
